cv32e40x_aes_rng: RTL



---
 rtl/cv32e40x_aes_rng_pkg.sv | 26 ++
 rtl/cv32e40x_aes_rng_fifo.sv | 47 ++++
 rtl/cv32e40x_aes_rng.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cv32e40x_aes_rng_pkg.sv
// Shared types, constants and the xorshift step for the AES mask generator.
package cv32e40x_aes_rng_pkg;

  localparam int RNG_WORD_W = 44;
  localparam logic [63:0] RNG_SEED_DEFAULT = 64'h9E37_79B9_7F4A_7C15;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    HALT   = 2'd2
  } rng_state_e;

  typedef struct packed {
    logic [35:0] bits;
    logic [7:0]  shareB;
  } rng_word_t;

  function automatic logic [63:0] rng_step(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

endpackage

// File: rtl/cv32e40x_aes_rng_fifo.sv
// Two-entry mask-word FIFO; flush wins over push and pop, push into a full FIFO needs a same-cycle pop.
module cv32e40x_aes_rng_fifo
  import cv32e40x_aes_rng_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  rng_word_t wdata,
  output rng_word_t rdata,
  output logic      full,
  output logic      empty
);

  rng_word_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       pop_ok;
  logic       push_ok;

  assign pop_ok  = pop && (cnt != 2'd0);
  assign push_ok = push && ((cnt != 2'd2) || pop_ok);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

endmodule

// File: rtl/cv32e40x_aes_rng.sv
// Xorshift64 mask source feeding the masked saes32 unit through a 2-entry FIFO.
// Optional repetition health test and HALT state: define CV32E40X_AES_RNG_HEALTH_EN.
module cv32e40x_aes_rng
  import cv32e40x_aes_rng_pkg::*;
#(
  parameter logic [63:0] SEED_DEFAULT  = RNG_SEED_DEFAULT,
  parameter int unsigned WARMUP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_valid_i,
  input  logic [63:0] seed_i,
  input  logic        rnd_ready_i,
  output logic        rnd_valid_o,
  output logic [7:0]  rnd_shareB_o,
  output logic [35:0] rnd_bits_o,
  output logic        busy_o,
  output logic        health_err_o
);

  localparam logic [7:0] WARMUP_LOAD = 8'(WARMUP_CYCLES);
  localparam rng_state_e START_STATE = (WARMUP_CYCLES == 0) ? RUN : WARMUP;

  rng_state_e  state_q;
  rng_state_e  state_d;
  logic [63:0] x_q;
  logic [63:0] x_next;
  logic [63:0] seed_eff;
  logic [7:0]  cnt_q;
  logic        gen;
  logic        step;
  logic        push;
  logic        pop;
  logic        flush;
  logic        rep_fail;
  logic        fifo_full;
  logic        fifo_empty;
  rng_word_t   head;
  rng_word_t   new_word;

  assign x_next   = rng_step(x_q);
  assign new_word = rng_word_t'(x_next[RNG_WORD_W-1:0]);
  assign seed_eff = (seed_i == 64'h0) ? SEED_DEFAULT : seed_i;
  assign pop      = !fifo_empty && rnd_ready_i;

`ifdef CV32E40X_AES_RNG_HEALTH_EN
  logic [RNG_WORD_W-1:0] prev_q;
  logic                  err_q;

  assign rep_fail = gen && (x_next[RNG_WORD_W-1:0] == prev_q);

  always_ff @(posedge clk) begin
    if (reset || seed_valid_i) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (gen)      prev_q <= x_next[RNG_WORD_W-1:0];
      if (rep_fail) err_q  <= 1'b1;
    end
  end

  assign health_err_o = err_q;
`else
  assign rep_fail     = 1'b0;
  assign health_err_o = 1'b0;
`endif

  assign push  = gen && !rep_fail;
  assign flush = seed_valid_i || rep_fail;

  always_ff @(posedge clk) begin
    if (reset) state_q <= START_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WARMUP:  if (cnt_q <= 8'd1) state_d = RUN;
      RUN:     if (rep_fail) state_d = HALT;
      default: ;
    endcase
    if (seed_valid_i) state_d = START_STATE;
  end

  // RUN only advances the generator when its word has a FIFO slot to land in.
  always_comb begin
    gen    = 1'b0;
    step   = 1'b0;
    busy_o = 1'b1;
    unique case (state_q)
      WARMUP: step = 1'b1;
      RUN: begin
        gen    = !fifo_full || pop;
        step   = gen;
        busy_o = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)             x_q <= SEED_DEFAULT;
    else if (seed_valid_i) x_q <= seed_eff;
    else if (step)         x_q <= x_next;
  end

  always_ff @(posedge clk) begin
    if (reset || seed_valid_i)  cnt_q <= WARMUP_LOAD;
    else if (state_q == WARMUP) cnt_q <= cnt_q - 8'd1;
  end

  cv32e40x_aes_rng_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (new_word),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rnd_valid_o  = !fifo_empty;
  assign rnd_shareB_o = fifo_empty ? 8'h0  : head.shareB;
  assign rnd_bits_o   = fifo_empty ? 36'h0 : head.bits;

endmodule
